// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared encodings and helpers for the pipeline hazard controller
package hazard_ctrl_pkg;

    // Decode-stage operand source selects
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    // Load-use sequencing state
    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_LU_STALL = 1'b1
    } hz_state_e;

    // Youngest producer wins: EX, then MEM, then WB, else register file
    function automatic fwd_sel_e pick_fwd(input logic hit_ex,
                                          input logic hit_mem,
                                          input logic hit_wb);
        if (hit_ex) begin
            return FWD_EX;
        end else if (hit_mem) begin
            return FWD_MEM;
        end else if (hit_wb) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_slot.sv
// rtl/hazard_slot.sv - one shadow scoreboard stage (rd, write-enable, load flag)
module hazard_slot #(
    parameter int REG_AW = 5
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              hold,
    input  logic              bubble,
    input  logic [REG_AW-1:0] nxt_rd,
    input  logic              nxt_we,
    input  logic              nxt_load,
    output logic [REG_AW-1:0] rd,
    output logic              we,
    output logic              load
);

    // Reset clears, hold freezes, bubble inserts a non-writing entry, else capture
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            rd   <= '0;
            we   <= 1'b0;
            load <= 1'b0;
        end else if (hold) begin
            rd   <= rd;
            we   <= we;
            load <= load;
        end else if (bubble) begin
            rd   <= '0;
            we   <= 1'b0;
            load <= 1'b0;
        end else begin
            rd   <= nxt_rd;
            we   <= nxt_we;
            load <= nxt_load;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, load-use stall, jump flush and freeze control for the 5-stage core
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int PERF_W = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rf_we,
    input  logic              id_is_load,
    input  logic              jump_flag,
    input  logic              ext_stall,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_flush
);

    logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
    logic              ex_we, mem_we, wb_we;
    logic              ex_load, mem_load, wb_load;

    logic              rs1_live, rs2_live;
    logic              a_ex, a_mem, a_wb;
    logic              b_ex, b_mem, b_wb;
    logic              lu_hazard;
    logic              lu_take;
    logic              jump_take;
    logic              ex_bubble;
    logic              unused_ok;
    hz_state_e         state;

    // A source only counts when it is really read and is not x0
    assign rs1_live  = id_valid & id_rs1_used & (id_rs1 != '0);
    assign rs2_live  = id_valid & id_rs2_used & (id_rs2 != '0);

    assign a_ex      = rs1_live & ex_we  & (ex_rd  == id_rs1);
    assign a_mem     = rs1_live & mem_we & (mem_rd == id_rs1);
    assign a_wb      = rs1_live & wb_we  & (wb_rd  == id_rs1);
    assign b_ex      = rs2_live & ex_we  & (ex_rd  == id_rs2);
    assign b_mem     = rs2_live & mem_we & (mem_rd == id_rs2);
    assign b_wb      = rs2_live & wb_we  & (wb_rd  == id_rs2);

    // Load data is not available until MEM, so an EX-stage load producer must stall
    assign lu_hazard = ex_load & (a_ex | b_ex);
    assign jump_take = ~cpu_rst & ~ext_stall & jump_flag;
    assign lu_take   = ~cpu_rst & ~ext_stall & ~jump_flag & lu_hazard;

    // ID enters EX only as a real instruction that is neither flushed nor stalled
    assign ex_bubble = ~id_valid | jump_flag | lu_hazard;

    // WB's load flag has no consumer; the slot keeps it for uniformity
    assign unused_ok = &{1'b0, wb_load};

    hazard_slot #(.REG_AW(REG_AW)) u_slot_ex (
        .cpu_clk  (cpu_clk),
        .cpu_rst  (cpu_rst),
        .hold     (ext_stall),
        .bubble   (ex_bubble),
        .nxt_rd   (id_rd),
        .nxt_we   (id_rf_we),
        .nxt_load (id_is_load),
        .rd       (ex_rd),
        .we       (ex_we),
        .load     (ex_load)
    );

    hazard_slot #(.REG_AW(REG_AW)) u_slot_mem (
        .cpu_clk  (cpu_clk),
        .cpu_rst  (cpu_rst),
        .hold     (ext_stall),
        .bubble   (1'b0),
        .nxt_rd   (ex_rd),
        .nxt_we   (ex_we),
        .nxt_load (ex_load),
        .rd       (mem_rd),
        .we       (mem_we),
        .load     (mem_load)
    );

    hazard_slot #(.REG_AW(REG_AW)) u_slot_wb (
        .cpu_clk  (cpu_clk),
        .cpu_rst  (cpu_rst),
        .hold     (ext_stall),
        .bubble   (1'b0),
        .nxt_rd   (mem_rd),
        .nxt_we   (mem_we),
        .nxt_load (mem_load),
        .rd       (wb_rd),
        .we       (wb_we),
        .load     (wb_load)
    );

    // Pipeline control with priority reset > freeze > jump > load-use
    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        fwd_a_sel   = FWD_RF;
        fwd_b_sel   = FWD_RF;
        if (!cpu_rst) begin
            if (ext_stall) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
            end else if (jump_flag) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (lu_hazard) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
            if (!lu_hazard) begin
                fwd_a_sel = pick_fwd(a_ex, a_mem, a_wb);
                fwd_b_sel = pick_fwd(b_ex, b_mem, b_wb);
            end
        end
    end

    // Load-use sequencer: a stall lasts exactly one unfrozen cycle
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state <= ST_RUN;
        end else if (!ext_stall) begin
            case (state)
                ST_RUN: begin
                    if (lu_take) begin
                        state <= ST_LU_STALL;
                    end
                end
                ST_LU_STALL: begin
                    assert (!lu_hazard);
                    state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Saturating event counters, frozen along with the pipe
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            perf_stall <= '0;
            perf_flush <= '0;
        end else begin
            if (lu_take && (perf_stall != '1)) begin
                perf_stall <= perf_stall + PERF_W'(1);
            end
            if (jump_take && (perf_flush != '1)) begin
                perf_flush <= perf_flush + PERF_W'(1);
            end
        end
    end

endmodule
